// File: rtl/mux_pkg.sv
// Shared select type and lane constants for the 4:1 lane selector.
// Pure declarations: no logic, no latency, no flow control.
package mux_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_L0 = 2'd0;
  localparam sel_t SEL_L1 = 2'd1;
  localparam sel_t SEL_L2 = 2'd2;
  localparam sel_t SEL_L3 = 2'd3;

  localparam int N_LANES = 4;

endpackage

// File: rtl/mux_4x1_comb.sv
// Combinational 4:1 lane select: lane = a[s], zero for an unknown select.
// Zero latency, no state, no backpressure.
module mux_4x1_comb
  import mux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [N_LANES*WIDTH-1:0] a,
  input  sel_t                     s,
  output logic [WIDTH-1:0]         lane
);

  always_comb begin
    lane = '0;
    case (s)
      SEL_L0:  lane = a[0*WIDTH +: WIDTH];
      SEL_L1:  lane = a[1*WIDTH +: WIDTH];
      SEL_L2:  lane = a[2*WIDTH +: WIDTH];
      SEL_L3:  lane = a[3*WIDTH +: WIDTH];
      // Only reachable in simulation with X/Z on s.
      default: lane = '0;
    endcase
  end

endmodule

// File: rtl/mux_4x1_reg.sv
// 4:1 lane selector with registered output; 1-cycle latency, fully pipelined.
// No backpressure: a new a/s may be presented every cycle under in_valid.
module mux_4x1_reg
  import mux_pkg::*;
#(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_LANES*WIDTH-1:0] a,
  input  sel_t                     s,
  input  logic                     in_valid,
  output logic [WIDTH-1:0]         y,
  output logic                     out_valid
);

  logic [WIDTH-1:0] lane;

  mux_4x1_comb #(
    .WIDTH (WIDTH)
  ) u_comb (
    .a    (a),
    .s    (s),
    .lane (lane)
  );

  // y only moves on a qualified capture; out_valid is a one-cycle strobe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y         <= RST_VAL;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        y <= lane;
      end
    end
  end

endmodule

// File: tb/tb_mux_4x1_reg.sv
// Directed bench for mux_4x1_reg at WIDTH=1 and WIDTH=8 (non-zero reset value).
// Both instances share clock, reset, select and valid.
module tb_mux_4x1_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  a;
  logic [1:0]  s;
  logic        in_valid;
  logic        y;
  logic        out_valid;

  logic [31:0] a8;
  logic [7:0]  y8;
  logic        out_valid8;

  int checks   = 0;
  int failures = 0;

  logic [7:0] lanes8 [4];
  logic [3:0] av;
  logic       exp_y;

  always #5 clk = ~clk;

  mux_4x1_reg #(
    .WIDTH   (1),
    .RST_VAL (1'b0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .s         (s),
    .in_valid  (in_valid),
    .y         (y),
    .out_valid (out_valid)
  );

  mux_4x1_reg #(
    .WIDTH   (8),
    .RST_VAL (8'h5A)
  ) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a8),
    .s         (s),
    .in_valid  (in_valid),
    .y         (y8),
    .out_valid (out_valid8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    lanes8[0] = 8'hA5;
    lanes8[1] = 8'h3C;
    lanes8[2] = 8'hFF;
    lanes8[3] = 8'h00;
    a8 = {lanes8[3], lanes8[2], lanes8[1], lanes8[0]};

    // Reset held for two edges while in_valid is asserted.
    rst_n = 1'b0; in_valid = 1'b1; a = 4'b1111; s = 2'd0;
    tick();
    tick();
    chk("rst_y",    {7'd0, y},           8'h00);
    chk("rst_ov",   {7'd0, out_valid},   8'h00);
    chk("rst_y8",   y8,                  8'h5A);
    chk("rst_ov8",  {7'd0, out_valid8},  8'h00);

    // First edge after reset release captures normally.
    rst_n = 1'b1; a = 4'b0010; s = 2'd1;
    tick();
    chk("post_rst_y",  {7'd0, y},         8'h01);
    chk("post_rst_ov", {7'd0, out_valid}, 8'h01);
    chk("post_rst_y8", y8,                8'h3C);

    // Exhaustive a x s, one vector per cycle.
    for (int ai = 0; ai < 16; ai++) begin
      for (int si = 0; si < 4; si++) begin
        av = ai[3:0];
        a  = av;
        s  = si[1:0];
        exp_y = av[si];
        tick();
        chk($sformatf("exh_a%0d_s%0d", ai, si), {7'd0, y}, {7'd0, exp_y});
        chk("exh_ov", {7'd0, out_valid}, 8'h01);
      end
    end

    a = 4'b0100; s = 2'd2;
    tick();
    chk("spot_0100_s2", {7'd0, y}, 8'h01);
    a = 4'b1011; s = 2'd2;
    tick();
    chk("spot_1011_s2", {7'd0, y}, 8'h00);
    chk("spot_y8_s2",   y8,        8'hFF);

    // Capture then hold with in_valid low.
    a = 4'b1000; s = 2'd3;
    tick();
    chk("hold_cap_y",  {7'd0, y}, 8'h01);
    chk("hold_cap_y8", y8,        8'h00);
    in_valid = 1'b0; a = 4'b0000; s = 2'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_y",   {7'd0, y},          8'h01);
      chk("hold_ov",  {7'd0, out_valid},  8'h00);
      chk("hold_y8",  y8,                 8'h00);
      chk("hold_ov8", {7'd0, out_valid8}, 8'h00);
    end

    // Back-to-back selects on a=0101.
    in_valid = 1'b1; a = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      s = i[1:0];
      tick();
      chk($sformatf("b2b_y_s%0d", i), {7'd0, y}, (i % 2 == 0) ? 8'h01 : 8'h00);
      chk("b2b_ov", {7'd0, out_valid}, 8'h01);
      chk($sformatf("b2b_y8_s%0d", i), y8, lanes8[i]);
    end

    // Reset landing on an edge that also carries a valid capture.
    a = 4'b1111; s = 2'd1; in_valid = 1'b1;
    tick();
    chk("mid_pre_y", {7'd0, y}, 8'h01);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_y",   {7'd0, y},         8'h00);
    chk("mid_rst_ov",  {7'd0, out_valid}, 8'h00);
    chk("mid_rst_y8",  y8,                8'h5A);
    rst_n = 1'b1; a = 4'b0001; s = 2'd0;
    tick();
    chk("mid_rel_y",  {7'd0, y},         8'h01);
    chk("mid_rel_ov", {7'd0, out_valid}, 8'h01);

    // Random pairs with 10-cycle spacing.
    for (int n = 0; n < 16; n++) begin
      av = 4'($urandom_range(0, 15));
      a  = av;
      s  = 2'($urandom_range(0, 3));
      exp_y = av[s];
      in_valid = 1'b1;
      tick();
      chk($sformatf("rnd%0d_y", n),  {7'd0, y}, {7'd0, exp_y});
      chk($sformatf("rnd%0d_y8", n), y8,        lanes8[s]);
      in_valid = 1'b0;
      a = ~av;
      for (int k = 0; k < 9; k++) tick();
      chk($sformatf("rnd%0d_hold", n),   {7'd0, y},         {7'd0, exp_y});
      chk($sformatf("rnd%0d_ov_lo", n),  {7'd0, out_valid}, 8'h00);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
